baud_tick_gen: RTL
==================

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter CNT_W, default 16, width of the integer divisor and cycle counter.
REQ-002 Parameter FRAC_W, default 4, width of the fractional divisor and accumulator.
REQ-003 Parameter OVERSAMPLE, default 16, os_tick pulses per bit_tick; power of two, 4..64.
REQ-004 Parameter RST_DIV, default 326, integer divisor loaded at reset (9600 baud x16 at 50 MHz, approx.).
REQ-005 clk  input  1  single clock; all logic on posedge clk.
REQ-006 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 enable  input  1  run when 1; when 0 the generator holds in its idle state.
REQ-008 resync  input  1  one-cycle pulse; restarts tick phase (RX start-bit alignment).
REQ-009 div_int  input  CNT_W  integer part of os_tick period, in clk cycles.
REQ-010 div_frac  input  FRAC_W  fractional part of os_tick period, in units of 1/2^FRAC_W cycle.
REQ-011 div_load  input  1  one-cycle pulse; captures div_int/div_frac into the shadow divisor.
REQ-012 os_tick  output  1  one-cycle pulse at the oversample rate.
REQ-013 bit_tick  output  1  one-cycle pulse once per OVERSAMPLE os_ticks.
REQ-014 mid_tick  output  1  one-cycle pulse at bit centre (see Configuration).
REQ-015 baud_clk  output  1  square wave, toggles on every bit_tick, idles high.
REQ-016 div_pending  output  1  high while a loaded divisor awaits application.

Function
REQ-017 The active divisor SHALL be (D, F), with D = active integer and F = active fraction.
REQ-018 D values 0 and 1 SHALL be clamped to 2 when captured.
REQ-019 The cycle counter SHALL count down, and os_tick SHALL assert in the cycle it reaches 0.
REQ-020 On each os_tick the accumulator SHALL add F modulo 2^FRAC_W; the counter SHALL reload D-1 on no carry and D on carry.
REQ-021 Over 2^FRAC_W os_ticks the total period SHALL be exactly D*2^FRAC_W + F cycles.
REQ-022 The sub-bit counter SHALL increment on each os_tick and wrap from OVERSAMPLE-1 to 0.
REQ-023 bit_tick SHALL assert in the same cycle as the os_tick that wraps the sub-bit counter to 0.
REQ-024 baud_clk SHALL toggle on the clock edge following each bit_tick.
REQ-025 div_load with enable=1 SHALL set div_pending; the shadow divisor SHALL become active at the next os_tick, and div_pending SHALL clear in that cycle.
REQ-026 div_load with enable=0 SHALL apply immediately; div_pending SHALL remain 0.
REQ-027 A second div_load before application SHALL overwrite the shadow divisor; only the last value SHALL be applied.
REQ-028 resync SHALL load the counter with D-1 and clear the accumulator and sub-bit counter; the first os_tick SHALL follow exactly D cycles after the resync edge.
REQ-029 resync coincident with os_tick SHALL suppress that os_tick and any bit_tick or mid_tick in the same cycle.
REQ-030 resync coincident with div_load SHALL capture the new divisor first, then restart using it.
REQ-031 enable=0 SHALL set the counter to D-1, clear the accumulator and sub-bit counter, force all ticks to 0 and baud_clk to 1, and keep the shadow divisor.
REQ-032 Rising enable SHALL behave as resync; the first os_tick SHALL follow D cycles later.

Reset
REQ-033 On rst_n low, os_tick, bit_tick and mid_tick SHALL be 0, and baud_clk SHALL be 1.
REQ-034 On rst_n low, div_pending, the accumulator and the sub-bit counter SHALL be 0.
REQ-035 On rst_n low, D SHALL be RST_DIV, F SHALL be 0 and the counter SHALL be RST_DIV-1.
REQ-036 Reset asserted mid-operation SHALL abort immediately with no partial tick.
REQ-037 Reset release SHALL be followed by normal operation on the first posedge with enable=1.

Configuration
REQ-038 Macro BAUD_TICK_GEN_MID_TICK_EN defined: mid_tick SHALL pulse with the os_tick that moves the sub-bit counter to OVERSAMPLE/2.
REQ-039 Macro BAUD_TICK_GEN_MID_TICK_EN absent: mid_tick SHALL be tied 0, with no comparator logic; the port SHALL be retained.

Verification
REQ-040 Reset, enable=1, D=326, F=0 -> os_tick every 326 cycles; bit_tick every 5216 cycles; baud_clk high until the first bit_tick.
REQ-041 div_load D=10, F=8 (FRAC_W=4) -> os_tick intervals alternate 10,11; 16 intervals total 168 cycles.
REQ-042 div_load D=20 mid-period, enable=1 -> div_pending high until the next os_tick; subsequent intervals are 20.
REQ-043 resync at an arbitrary cycle with D=12 -> os_tick exactly 12 cycles later; bit_tick after 16 os_ticks; coincident os_tick suppressed.
REQ-044 div_int=0 and div_int=1 -> os_tick interval 2; enable dropped mid-bit -> ticks stop and baud_clk=1 on the next edge.
REQ-045 Macro defined, OVERSAMPLE=16, D=4 -> mid_tick 32 cycles after bit-phase start; macro absent -> mid_tick constant 0.

Source files
------------

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional-N oversample / bit tick generator for a UART.
// A down-counter paced by an integer divisor D, stretched by one cycle
// whenever the FRAC_W-bit phase accumulator (stepping by F) carries, gives
// os_tick. OVERSAMPLE os_ticks make one bit_tick; baud_clk toggles per bit.
// Optional feature macro: BAUD_TICK_GEN_MID_TICK_EN enables the bit-centre
// mid_tick comparator; without it mid_tick is tied low.
module baud_tick_gen #(
  parameter int CNT_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVERSAMPLE = 16,
  parameter int RST_DIV    = 326
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              resync,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick,
  output logic              baud_clk,
  output logic              div_pending
);

  localparam int               SUB_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] RST_D = CNT_W'(RST_DIV);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [CNT_W-1:0]  d_q, d_d, sd_q, sd_d;
  logic [FRAC_W-1:0] f_q, f_d, sf_q, sf_d;
  logic              pend_q, pend_d;
  logic              baud_q, baud_d;
  logic              ena_q;

  logic [CNT_W-1:0]  ld_int;
  logic              restart;
  logic              os_w, bit_w;
  logic [FRAC_W:0]   acc_sum;

  // Tick decode: a restart (resync or enable rising) swallows a coincident tick.
  always_comb begin
    ld_int  = (div_int < CNT_W'(2)) ? CNT_W'(2) : div_int;
    restart = enable & (resync | ~ena_q);
    os_w    = enable & ~restart & (cnt_q == '0);
    bit_w   = os_w & (sub_q == SUB_W'(OVERSAMPLE - 1));
  end

  // Next state: divisor capture/apply, counter, accumulator, sub-bit, baud_clk.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sub_d   = sub_q;
    d_d     = d_q;
    f_d     = f_q;
    sd_d    = sd_q;
    sf_d    = sf_q;
    pend_d  = pend_q;
    baud_d  = baud_q;
    acc_sum = '0;
    if (!enable) begin
      // Idle: a load takes effect at once, nothing can be left pending by it.
      if (div_load) begin
        d_d    = ld_int;
        f_d    = div_frac;
        sd_d   = ld_int;
        sf_d   = div_frac;
        pend_d = 1'b0;
      end
      cnt_d  = d_d - CNT_W'(1);
      acc_d  = '0;
      sub_d  = '0;
      baud_d = 1'b1;
    end else if (restart) begin
      // Capture first so the restarted phase already runs on the new divisor.
      if (div_load) begin
        d_d    = ld_int;
        f_d    = div_frac;
        sd_d   = ld_int;
        sf_d   = div_frac;
        pend_d = 1'b0;
      end
      cnt_d = d_d - CNT_W'(1);
      acc_d = '0;
      sub_d = '0;
    end else if (os_w) begin
      // A load landing on a tick waits for the following tick.
      if (div_load) begin
        sd_d   = ld_int;
        sf_d   = div_frac;
        pend_d = 1'b1;
      end else if (pend_q) begin
        d_d    = sd_q;
        f_d    = sf_q;
        pend_d = 1'b0;
      end
      acc_sum = {1'b0, acc_q} + {1'b0, f_d};
      acc_d   = acc_sum[FRAC_W-1:0];
      cnt_d   = acc_sum[FRAC_W] ? d_d : d_d - CNT_W'(1);
      sub_d   = sub_q + SUB_W'(1);
      if (bit_w) baud_d = ~baud_q;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_load) begin
        sd_d   = ld_int;
        sf_d   = div_frac;
        pend_d = 1'b1;
      end
    end
  end

  // State registers; ena_q resets high so leaving reset with enable=1 is not a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= RST_D - CNT_W'(1);
      acc_q  <= '0;
      sub_q  <= '0;
      d_q    <= RST_D;
      f_q    <= '0;
      sd_q   <= RST_D;
      sf_q   <= '0;
      pend_q <= 1'b0;
      baud_q <= 1'b1;
      ena_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      sub_q  <= sub_d;
      d_q    <= d_d;
      f_q    <= f_d;
      sd_q   <= sd_d;
      sf_q   <= sf_d;
      pend_q <= pend_d;
      baud_q <= baud_d;
      ena_q  <= enable;
    end
  end

  assign os_tick     = os_w;
  assign bit_tick    = bit_w;
  assign baud_clk    = baud_q;
  assign div_pending = pend_q;

`ifdef BAUD_TICK_GEN_MID_TICK_EN
  // Bit centre: the tick that moves the sub-bit counter to OVERSAMPLE/2.
  assign mid_tick = os_w & (sub_q == SUB_W'(OVERSAMPLE / 2 - 1));
`else
  assign mid_tick = 1'b0;
`endif

endmodule
